// File: rtl/stream_seq_checker_if.sv
// rtl/stream_seq_checker_if.sv - valid/ready byte stream interface between counter source and checker sink
//
// Signals:
//   valid : source -> sink, data word is valid
//   data  : source -> sink, DATA_WIDTH-bit payload
//   ready : sink -> source, sink will accept on this edge
// Modports:
//   master : stream source (drives valid/data)
//   slave  : stream sink   (drives ready)
interface stream_seq_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_seq_checker.sv
// rtl/stream_seq_checker.sv - incrementing-sequence stream sink with LFSR backpressure and error counting
//
// Ports:
//   clock          : clock, all state on posedge
//   reset          : synchronous active-high reset
//   enable         : permits ready; low means no transfers accepted
//   target         : number of transfers to accept before done
//   s              : stream_seq_checker_if.slave (valid, data in; ready out, registered)
//   done           : sticky, received_count reached target
//   error          : sticky, at least one mismatch seen
//   received_count : accepted transfers
//   error_count    : mismatches, saturating
// Optional (macro STREAM_SEQ_CHECKER_CAPTURE_EN):
//   first_err_expected, first_err_actual, first_err_index : snapshot of the first mismatch
module stream_seq_checker #(
  parameter int              DATA_WIDTH      = 8,
  parameter int              COUNT_WIDTH     = 16,
  parameter int              READY_THRESHOLD = 12,
  parameter logic [15:0]     LFSR_SEED       = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] target,
  stream_seq_checker_if.slave    s,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] received_count,
  output logic [COUNT_WIDTH-1:0] error_count
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0]  first_err_expected,
  output logic [DATA_WIDTH-1:0]  first_err_actual,
  output logic [COUNT_WIDTH-1:0] first_err_index
`endif
);

  // 5 bits so that a threshold of 16 (always ready) is representable
  localparam logic [4:0]  READY_TH  = 5'(READY_THRESHOLD);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  logic [15:0]            lfsr;
  logic [15:0]            lfsr_next;
  logic [DATA_WIDTH-1:0]  expected;
  logic                   ready_q;
  logic                   xfer;
  logic                   mismatch;
  logic                   done_next;
  logic [COUNT_WIDTH-1:0] count_next;

  assign s.ready = ready_q;

  always_comb begin
    lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    xfer       = s.valid && ready_q;
    mismatch   = xfer && (s.data != expected);
    count_next = received_count + COUNT_WIDTH'(xfer);
    // Comparing the post-transfer count lets done and ready fall on the same
    // edge, and makes target=0 complete on the first edge out of reset.
    done_next  = done || (count_next == target);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr           <= LFSR_SEED;
      ready_q        <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      received_count <= '0;
      error_count    <= '0;
      expected       <= '0;
    end else begin
      lfsr           <= lfsr_next;
      done           <= done_next;
      ready_q        <= enable && !done_next && ({1'b0, lfsr_next[3:0]} < READY_TH);
      received_count <= count_next;
      if (xfer) begin
        if (mismatch) begin
          error <= 1'b1;
          if (error_count != '1)
            error_count <= error_count + 1'b1;
          // Resynchronise on the received word so one fault counts once
          expected <= s.data + 1'b1;
        end else begin
          expected <= expected + 1'b1;
        end
      end
    end
  end

`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      first_err_expected <= '0;
      first_err_actual   <= '0;
      first_err_index    <= '0;
    end else if (mismatch && !error) begin
      first_err_expected <= expected;
      first_err_actual   <= s.data;
      first_err_index    <= received_count;
    end
  end
`endif

endmodule

// File: tb/tb_stream_seq_checker.sv
// tb/tb_stream_seq_checker.sv - randomized self-checking bench for stream_seq_checker against a reference model
module tb_stream_seq_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] target = 16'd0;
  logic [15:0] target2 = 16'd1000;

  logic        done, error, done2, error2;
  logic [15:0] rcnt, ecnt, rcnt2, ecnt2;
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
  logic [7:0]  fe_exp, fe_act, fe_exp2, fe_act2;
  logic [15:0] fe_idx, fe_idx2;
`endif

  stream_seq_checker_if #(.DATA_WIDTH(8)) s_if ();
  stream_seq_checker_if #(.DATA_WIDTH(8)) f_if ();

  always #5 clock = ~clock;

  stream_seq_checker dut (
    .clock(clock), .reset(reset), .enable(enable), .target(target), .s(s_if),
    .done(done), .error(error), .received_count(rcnt), .error_count(ecnt)
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
    , .first_err_expected(fe_exp), .first_err_actual(fe_act), .first_err_index(fe_idx)
`endif
  );

  stream_seq_checker #(.READY_THRESHOLD(16)) dut_full (
    .clock(clock), .reset(reset), .enable(enable), .target(target2), .s(f_if),
    .done(done2), .error(error2), .received_count(rcnt2), .error_count(ecnt2)
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
    , .first_err_expected(fe_exp2), .first_err_actual(fe_act2), .first_err_index(fe_idx2)
`endif
  );

  typedef struct {
    logic [15:0] lfsr;
    logic [7:0]  exp;
    int          rcnt;
    int          ecnt;
    bit          ready;
    bit          done;
    bit          error;
    logic [7:0]  cexp;
    logic [7:0]  cact;
    int          cidx;
  } model_t;

  model_t     m1, m2;
  int         total = 0;
  int         bad = 0;
  int         idx = 0;
  int         idx2 = 0;
  int         valid_pct = 100;
  logic [7:0] words[$];
  int         duty_cycles = 0;
  int         duty_ready = 0;
  bit         measure = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the sink as stated by its rules: consume, compare, count, finish, then offer.
  function automatic model_t step(model_t m, bit rst, bit en, int tgt, bit v, logic [7:0] d, int thr);
    model_t n = m;
    if (rst) begin
      n.lfsr = 16'hACE1; n.exp = 8'd0; n.rcnt = 0; n.ecnt = 0;
      n.ready = 0; n.done = 0; n.error = 0; n.cexp = 0; n.cact = 0; n.cidx = 0;
      return n;
    end
    if (v && m.ready) begin
      if (d == m.exp) begin
        n.exp = m.exp + 8'd1;
      end else begin
        if (!m.error) begin
          n.cexp = m.exp; n.cact = d; n.cidx = m.rcnt;
        end
        n.error = 1;
        if (m.ecnt < 65535) n.ecnt = m.ecnt + 1;
        n.exp = d + 8'd1;
      end
      n.rcnt = m.rcnt + 1;
    end
    if (n.rcnt == tgt) n.done = 1;
    n.lfsr = (m.lfsr >> 1) ^ (m.lfsr[0] ? 16'hB400 : 16'h0000);
    n.ready = en && !n.done && (int'(n.lfsr[3:0]) < thr);
    return n;
  endfunction

  function automatic logic [7:0] src_word(int i);
    if (i < words.size()) return words[i];
    return i[7:0];
  endfunction

  task automatic tick();
    bit acc1 = s_if.valid && s_if.ready;
    bit acc2 = f_if.valid && f_if.ready;
    if (measure && enable && !m1.done) begin
      duty_cycles++;
      if (s_if.ready) duty_ready++;
    end
    m1 = step(m1, reset, enable, int'(target), s_if.valid, s_if.data, 12);
    m2 = step(m2, reset, enable, int'(target2), f_if.valid, f_if.data, 16);
    @(posedge clock);
    #1;
    check("ready",  32'(s_if.ready), 32'(m1.ready));
    check("done",   32'(done),       32'(m1.done));
    check("error",  32'(error),      32'(m1.error));
    check("rcnt",   32'(rcnt),       32'(m1.rcnt));
    check("ecnt",   32'(ecnt),       32'(m1.ecnt));
    check("ready16", 32'(f_if.ready), 32'(m2.ready));
    check("done16",  32'(done2),      32'(m2.done));
    check("rcnt16",  32'(rcnt2),      32'(m2.rcnt));
    check("ecnt16",  32'(ecnt2),      32'(m2.ecnt));
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
    check("fe_exp", 32'(fe_exp), 32'(m1.cexp));
    check("fe_act", 32'(fe_act), 32'(m1.cact));
    check("fe_idx", 32'(fe_idx), 32'(m1.cidx));
`endif
    if (reset) begin
      idx = 0; idx2 = 0;
    end else begin
      if (acc1) idx++;
      if (acc2) idx2++;
    end
    if (acc1 || !s_if.valid) s_if.valid = ($urandom_range(99) < valid_pct);
    s_if.data = src_word(idx);
    f_if.data = idx2[7:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = 8'd0;
    f_if.valid = 1'b1;
    f_if.data  = 8'd0;

    // A: long always-valid run through several 8'hFF -> 8'h00 wraps
    target = 16'd1000; enable = 1'b1; valid_pct = 100; words = {};
    do_reset();
    run_until_done("a_done", 4000);
    check("a_rcnt", 32'(rcnt), 32'd1000);
    check("a_ecnt", 32'(ecnt), 32'd0);
    check("a_err",  32'(error), 32'd0);
    tick();
    check("a_rdy0", 32'(s_if.ready), 32'd0);
    check("a16_done", 32'(done2), 32'd1);
    check("a16_rcnt", 32'(rcnt2), 32'd1000);

    // B: random valid gaps, measure ready duty
    target = 16'd300; valid_pct = 70;
    do_reset();
    measure = 1;
    run_until_done("b_done", 3000);
    measure = 0;
    check("b_ecnt", 32'(ecnt), 32'd0);
    check("b_duty", 32'(duty_ready * 100 >= duty_cycles * 70 &&
                        duty_ready * 100 <= duty_cycles * 80), 32'd1);

    // C: corrupt 4th word, following word mismatches once more
    target = 16'd10; valid_pct = 100;
    words = {8'h00, 8'h01, 8'h02, 8'h05, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    do_reset();
    run_until_done("c_done", 200);
    check("c_ecnt", 32'(ecnt), 32'd2);
    check("c_err",  32'(error), 32'd1);
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
    check("c_fexp", 32'(fe_exp), 32'h03);
    check("c_fact", 32'(fe_act), 32'h05);
    check("c_fidx", 32'(fe_idx), 32'd3);
`endif

    // D: skipped value resynchronises after one error
    target = 16'd5;
    words = {8'h00, 8'h01, 8'h02, 8'h04, 8'h05};
    do_reset();
    run_until_done("d_done", 200);
    check("d_ecnt", 32'(ecnt), 32'd1);
    words = {};

    // E: zero target completes immediately
    target = 16'd0;
    do_reset();
    tick();
    check("e_done", 32'(done), 32'd1);
    check("e_rdy",  32'(s_if.ready), 32'd0);
    check("e_rcnt", 32'(rcnt), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("e_rdy2", 32'(s_if.ready), 32'd0);

    // F: enable gap after 10 transfers, then mid-stream reset
    target = 16'd100; valid_pct = 100;
    do_reset();
    for (int n = 0; n < 300 && m1.rcnt < 10; n++) tick();
    check("f_ten", 32'(rcnt), 32'd10);
    valid_pct = 0; s_if.valid = 1'b0; enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i > 0) check("f_gaprdy", 32'(s_if.ready), 32'd0);
    end
    check("f_hold", 32'(rcnt), 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("f_rst_rcnt", 32'(rcnt), 32'd0);
    check("f_rst_done", 32'(done), 32'd0);
    check("f_rst_rdy",  32'(s_if.ready), 32'd0);
    enable = 1'b1; valid_pct = 100; s_if.valid = 1'b1; s_if.data = 8'h00;
    for (int n = 0; n < 200 && m1.rcnt < 1; n++) tick();
    check("f_first", 32'(rcnt), 32'd1);
    check("f_ecnt",  32'(ecnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
